// File: rtl/evr_pulse_generator.sv
// evr_pulse_generator: delayed, programmable-width pulse launched by one EVR
// event strobe. Latches the timestamp at the trigger and counts accepted and
// missed triggers. Everything runs in the EVR recovered-clock domain.
module evr_pulse_generator #(
  parameter int DELAY_WIDTH     = 32,
  parameter int WIDTH_WIDTH     = 24,
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic                       evrRxClk,
  input  logic                       evrRxReset,
  input  logic                       trigger,
  input  logic                       enable,
  input  logic                       invert,
  input  logic [DELAY_WIDTH-1:0]     delay,
  input  logic [WIDTH_WIDTH-1:0]     width,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic                       timestampValid,
  output logic                       pulse,
  output logic                       busy,
  output logic [TIMESTAMP_WIDTH-1:0] triggerTimestamp,
  output logic                       triggerTimestampValid,
  output logic [31:0]                acceptedCount,
  output logic [15:0]                missedCount
);

  // One down-counter serves both the delay and the width phase.
  localparam int CNT_WIDTH = (DELAY_WIDTH > WIDTH_WIDTH) ? DELAY_WIDTH : WIDTH_WIDTH;

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} stateT;

  stateT                  state, stateNext;
  logic [CNT_WIDTH-1:0]   cnt, cntNext;
  logic                   raw, rawNext;
  logic [WIDTH_WIDTH-1:0] wReg;
  logic                   accept, miss;

  // Next-state logic; delay/width are only looked at on accept so a pulse in
  // flight is immune to register changes.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    rawNext   = raw;
    accept    = 1'b0;
    miss      = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && enable) begin
          accept = 1'b1;
          if (width != '0) begin
            if (delay == '0) begin
              stateNext = ACTIVE;
              rawNext   = 1'b1;
              cntNext   = CNT_WIDTH'(width) - CNT_WIDTH'(1);
            end else begin
              stateNext = DELAY;
              cntNext   = CNT_WIDTH'(delay) - CNT_WIDTH'(1);
            end
          end
        end
      end
      DELAY: begin
        if (!enable) begin
          stateNext = IDLE;
          rawNext   = 1'b0;
        end else begin
          miss = trigger;
          if (cnt == '0) begin
            stateNext = ACTIVE;
            rawNext   = 1'b1;
            cntNext   = CNT_WIDTH'(wReg) - CNT_WIDTH'(1);
          end else begin
            cntNext = cnt - CNT_WIDTH'(1);
          end
        end
      end
      ACTIVE: begin
        if (!enable) begin
          stateNext = IDLE;
          rawNext   = 1'b0;
        end else begin
          miss = trigger;
          if (cnt == '0) begin
            stateNext = IDLE;
            rawNext   = 1'b0;
          end else begin
            cntNext = cnt - CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        rawNext   = 1'b0;
      end
    endcase
  end

  // State, counters and trigger latches; reset wins over a same-edge trigger.
  always_ff @(posedge evrRxClk) begin
    if (evrRxReset) begin
      state                 <= IDLE;
      cnt                   <= '0;
      raw                   <= 1'b0;
      wReg                  <= '0;
      triggerTimestamp      <= '0;
      triggerTimestampValid <= 1'b0;
      acceptedCount         <= '0;
      missedCount           <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      raw   <= rawNext;
      if (accept) begin
        wReg                  <= width;
        triggerTimestamp      <= timestamp;
        triggerTimestampValid <= timestampValid;
        acceptedCount         <= acceptedCount + 32'd1;
      end
      if (miss && (missedCount != 16'hFFFF))
        missedCount <= missedCount + 16'd1;
    end
  end

  assign busy  = (state != IDLE);
  assign pulse = raw ^ invert;

endmodule

// File: tb/tb_evr_pulse_generator.sv
// Directed bench for evr_pulse_generator. After the trigger edge T, sample k
// (taken #1 after edge T+k-1) is the value seen at edge T+k.
module tb_evr_pulse_generator;

  logic        evrRxClk = 1'b0;
  logic        evrRxReset, trigger, enable, invert;
  logic [31:0] delay;
  logic [23:0] width;
  logic [63:0] timestamp;
  logic        timestampValid;
  logic        pulse, busy;
  logic [63:0] triggerTimestamp;
  logic        triggerTimestampValid;
  logic [31:0] acceptedCount;
  logic [15:0] missedCount;

  int          nTests = 0;
  int          nFail  = 0;
  int          k;
  logic [63:0] pulseSeen, busySeen;

  evr_pulse_generator dut (
    .evrRxClk(evrRxClk), .evrRxReset(evrRxReset), .trigger(trigger),
    .enable(enable), .invert(invert), .delay(delay), .width(width),
    .timestamp(timestamp), .timestampValid(timestampValid),
    .pulse(pulse), .busy(busy), .triggerTimestamp(triggerTimestamp),
    .triggerTimestampValid(triggerTimestampValid),
    .acceptedCount(acceptedCount), .missedCount(missedCount)
  );

  always #5 evrRxClk = ~evrRxClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge evrRxClk);
    #1;
  endtask

  task automatic rec();
    pulseSeen[k] = pulse;
    busySeen[k]  = busy;
  endtask

  // Trigger sampled at edge T; first record is the value at edge T+1.
  task automatic fire();
    pulseSeen = '0;
    busySeen  = '0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    k = 1;
    rec();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      k++;
      rec();
    end
  endtask

  initial begin
    evrRxReset = 1'b1; trigger = 1'b1; enable = 1'b1; invert = 1'b0;
    delay = 32'd0; width = 24'd1; timestamp = 64'h1234; timestampValid = 1'b1;
    repeat (3) step();
    // reset held with trigger present: nothing accepted
    chk("rst_pulse", {63'd0, pulse}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_acc", {32'd0, acceptedCount}, 64'd0);
    chk("rst_miss", {48'd0, missedCount}, 64'd0);
    chk("rst_ts", triggerTimestamp, 64'd0);
    chk("rst_tsv", {63'd0, triggerTimestampValid}, 64'd0);
    trigger = 1'b0; evrRxReset = 1'b0;
    step();

    // case 1: delay 0, width 1
    delay = 32'd0; width = 24'd1;
    fire(); run(5);
    chk("c1_pulse", pulseSeen, 64'h2);
    chk("c1_busy", busySeen, 64'h2);
    chk("c1_acc", {32'd0, acceptedCount}, 64'd1);

    // case 2: delay 5, width 3, timestamp latch; mid-flight register changes ignored
    delay = 32'd5; width = 24'd3; timestamp = 64'h0000_0010_0000_0200; timestampValid = 1'b1;
    fire();
    delay = 32'd1; width = 24'd7; timestamp = 64'h5555;
    run(10);
    chk("c2_pulse", pulseSeen, 64'h1C0);
    chk("c2_busy", busySeen, 64'h1FE);
    chk("c2_ts", triggerTimestamp, 64'h0000_0010_0000_0200);
    chk("c2_tsv", {63'd0, triggerTimestampValid}, 64'd1);
    chk("c2_acc", {32'd0, acceptedCount}, 64'd2);

    // case 3: retrigger during pulse is ignored and counted
    delay = 32'd2; width = 24'd4;
    fire(); run(2);
    trigger = 1'b1; run(1); trigger = 1'b0;
    run(5);
    chk("c3_pulse", pulseSeen, 64'h78);
    chk("c3_miss", {48'd0, missedCount}, 64'd1);
    chk("c3_acc", {32'd0, acceptedCount}, 64'd3);

    // case 4: width 0 counts and latches only
    delay = 32'd3; width = 24'd0; timestamp = 64'hDEAD_BEEF_0000_0001; timestampValid = 1'b0;
    fire(); run(5);
    chk("c4_pulse", pulseSeen, 64'h0);
    chk("c4_busy", busySeen, 64'h0);
    chk("c4_acc", {32'd0, acceptedCount}, 64'd4);
    chk("c4_ts", triggerTimestamp, 64'hDEAD_BEEF_0000_0001);
    chk("c4_tsv", {63'd0, triggerTimestampValid}, 64'd0);

    // case 5: enable dropped at T+12 truncates the pulse
    delay = 32'd10; width = 24'd10; timestampValid = 1'b1;
    fire(); run(11);
    enable = 1'b0; run(3); enable = 1'b1;
    chk("c5_pulse", pulseSeen, 64'h1800);
    chk("c5_busy", busySeen, 64'h1FFE);
    chk("c5_acc", {32'd0, acceptedCount}, 64'd5);
    chk("c5_miss", {48'd0, missedCount}, 64'd1);

    // trigger while disabled is ignored entirely
    enable = 1'b0; trigger = 1'b1; step(); trigger = 1'b0; enable = 1'b1;
    chk("dis_acc", {32'd0, acceptedCount}, 64'd5);

    // missed counter saturation: hold trigger through a long delay
    delay = 32'd100000; width = 24'd1;
    trigger = 1'b1;
    repeat (65540) step();
    trigger = 1'b0;
    chk("sat_miss", {48'd0, missedCount}, 64'hFFFF);
    chk("sat_acc", {32'd0, acceptedCount}, 64'd6);
    chk("sat_busy", {63'd0, busy}, 64'd1);
    enable = 1'b0; step(); enable = 1'b1;
    chk("sat_abort", {63'd0, busy}, 64'd0);

    // case 6: inverted output, reset asserted at T+7
    invert = 1'b1; step();
    chk("c6_idle", {63'd0, pulse}, 64'd1);
    delay = 32'd5; width = 24'd3; timestamp = 64'h0000_0010_0000_0200;
    fire(); run(6);
    evrRxReset = 1'b1; run(1); evrRxReset = 1'b0;
    run(2);
    chk("c6_pulse", pulseSeen, 64'h73E);
    chk("c6_acc", {32'd0, acceptedCount}, 64'd0);
    chk("c6_miss", {48'd0, missedCount}, 64'd0);
    chk("c6_ts", triggerTimestamp, 64'd0);
    chk("c6_busy", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
